// File: rtl/uart_msg_sequencer.sv
// rtl/uart_msg_sequencer.sv - queues colour/node events and streams ASCII status frames to the UART TX
// Optional feature macro: MSG_CRLF_EN (appends CR LF to every frame)
module uart_msg_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       event_valid,
  input  logic [2:0] event_color,
  input  logic [3:0] event_node,
  output logic       event_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] msg_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef MSG_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd11;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  // event queue storage: entry = {color, node}
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ready_q;
  logic          overflow_q;

  // frame sequencer state
  state_t        state_q;
  logic [2:0]    color_q;
  logic [3:0]    node_q;
  logic [3:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    tx_byte_q;
  logic          tx_valid_q;
  logic [7:0]    msg_count_q;

  logic       push;
  logic       pop;
  logic [6:0] head;

  // colour 0 means "no event": it is handshaken but never stored
  assign push = event_valid & ready_q & (event_color != 3'd0);
  // only LOAD pops, and LOAD is entered solely with a non-empty queue
  assign pop  = (state_q == S_LOAD);
  assign head = mem_q[rd_ptr_q];

  // ASCII byte at position idx of the frame "SI-W<d>-<c1><c2>-#"
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [2:0] color,
                                            input logic [3:0] node);
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] digit;
    logic [7:0] b;
    case (color)
      3'd1:    begin c1 = 8'h46; c2 = 8'h49; end
      3'd2:    begin c1 = 8'h43; c2 = 8'h54; end
      3'd3:    begin c1 = 8'h53; c2 = 8'h53; end
      default: begin c1 = 8'h58; c2 = 8'h58; end
    endcase
    digit = (node > 4'd9) ? 8'h58 : (8'h30 + {4'd0, node});
    case (idx)
      4'd0:    b = 8'h53;
      4'd1:    b = 8'h49;
      4'd2:    b = 8'h2D;
      4'd3:    b = 8'h57;
      4'd4:    b = digit;
      4'd5:    b = 8'h2D;
      4'd6:    b = c1;
      4'd7:    b = c2;
      4'd8:    b = 8'h2D;
      4'd9:    b = 8'h23;
`ifdef MSG_CRLF_EN
      4'd10:   b = 8'h0D;
      4'd11:   b = 8'h0A;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // next queue occupancy; simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // queue storage writes (data needs no reset, pointers gate validity)
  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {event_color, event_node};
    end
  end

  // queue pointers, occupancy, registered ready and sticky overflow
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CW'(FIFO_DEPTH));
      if (event_valid && !ready_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // frame FSM with registered tx outputs; tx_byte/tx_valid only change on a transfer
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      color_q     <= '0;
      node_q      <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      msg_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          color_q    <= head[6:4];
          node_q     <= head[3:0];
          idx_q      <= 4'd0;
          tx_byte_q  <= frame_byte(4'd0, head[6:4], head[3:0]);
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q  <= 1'b0;
              msg_count_q <= msg_count_q + 8'd1;
              gap_q       <= '0;
              state_q     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_byte_q <= frame_byte(idx_q + 4'd1, color_q, node_q);
            end
          end
        end
        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign event_ready = ready_q;
  assign overflow    = overflow_q;
  assign tx_byte     = tx_byte_q;
  assign tx_valid    = tx_valid_q;
  assign msg_count   = msg_count_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb/tb_uart_msg_sequencer.sv - scoreboard bench for uart_msg_sequencer
module tb_uart_msg_sequencer;

  localparam int GAP = 16;
`ifdef MSG_CRLF_EN
  localparam int FRAME_LEN = 12;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       event_valid = 1'b0;
  logic [2:0] event_color = 3'd0;
  logic [3:0] event_node = 4'd0;
  logic       event_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       overflow;
  logic [7:0] msg_count;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  int         xfer_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  uart_msg_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .event_valid(event_valid),
    .event_color(event_color),
    .event_node (event_node),
    .event_ready(event_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overflow   (overflow),
    .msg_count  (msg_count)
  );

  always #10 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [2:0] color, input logic [3:0] node);
    logic [7:0] c1;
    logic [7:0] c2;
    case (color)
      3'd1:    begin c1 = "F"; c2 = "I"; end
      3'd2:    begin c1 = "C"; c2 = "T"; end
      3'd3:    begin c1 = "S"; c2 = "S"; end
      default: begin c1 = "X"; c2 = "X"; end
    endcase
    sb.push_back("S");
    sb.push_back("I");
    sb.push_back("-");
    sb.push_back("W");
    sb.push_back((node <= 4'd9) ? (8'd48 + 8'(node)) : 8'h58);
    sb.push_back("-");
    sb.push_back(c1);
    sb.push_back(c2);
    sb.push_back("-");
    sb.push_back("#");
`ifdef MSG_CRLF_EN
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
`endif
  endtask

  // called at posedge+1; returns at posedge+1 after the offering edge
  task automatic send_event(input logic [2:0] color, input logic [3:0] node, input bit accept);
    event_color = color;
    event_node  = node;
    event_valid = 1'b1;
    if (accept && color != 3'd0) push_frame(color, node);
    @(posedge CLOCK);
    #1;
    event_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (!busy) break;
    end
    check("idle_reached", 32'(i < budget), 1);
    @(posedge CLOCK);
    #1;
  endtask

  // output monitor: scoreboard compare on every transfer, hold check on every stall
  always @(negedge CLOCK) begin
    logic [7:0] e;
    if (RESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_byte", tx_byte, prev_byte);
      end
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        check("tx_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tx_byte", tx_byte, e);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
    end
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gap;
    int cyc;

    // reset values
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_event_ready", event_ready, 1);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_msg_count", msg_count, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    // single event, tx_ready held high, latency from accept
    tx_ready = 1'b1;
    send_event(3'd1, 4'd3, 1);
    @(negedge CLOCK);
    check("lat_edge_k", tx_valid, 0);
    check("busy_after_accept", busy, 1);
    @(negedge CLOCK);
    check("lat_edge_k1", tx_valid, 0);
    @(negedge CLOCK);
    check("lat_edge_k2", tx_valid, 1);
    wait_idle(200);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_msg_count", msg_count, 1);

    // slow UART: one ready pulse every 434 clocks
    tx_ready = 1'b0;
    send_event(3'd3, 4'd7, 1);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(posedge CLOCK);
      #1;
      tx_ready = (cyc % 434 == 433);
      cyc++;
    end
    tx_ready = 1'b0;
    check("t2_finished", busy, 0);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_msg_count", msg_count, 2);

    // fill the queue behind a stalled frame, then overflow
    send_event(3'd1, 4'd1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      if (tx_valid) break;
    end
    check("t3_stalled_valid", tx_valid, 1);
    @(posedge CLOCK);
    #1;
    send_event(3'd2, 4'd2, 1);
    send_event(3'd3, 4'd3, 1);
    send_event(3'd1, 4'd4, 1);
    check("t3_ready_before_4th", event_ready, 1);
    send_event(3'd4, 4'd5, 1);
    check("t3_ready_low", event_ready, 0);
    check("t3_no_overflow_yet", overflow, 0);
    send_event(3'd2, 4'd6, 0);
    check("t3_overflow", overflow, 1);
    tx_ready = 1'b1;
    wait_idle(1000);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_msg_count", msg_count, 7);
    check("t3_ready_back", event_ready, 1);

    // colour 0 is dropped; colour 6 / node 12 maps to X everywhere
    send_event(3'd0, 4'd5, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      check("t4_busy_color0", busy, 0);
    end
    @(posedge CLOCK);
    #1;
    send_event(3'd6, 4'd12, 1);
    wait_idle(200);
    check("t4_sb_empty", sb.size(), 0);
    check("t4_msg_count", msg_count, 8);

    // inter-frame gap: GAP clocks plus IDLE and LOAD
    base = xfer_cnt;
    send_event(3'd5, 4'd9, 1);
    send_event(3'd7, 4'd1, 1);
    for (int i = 0; i < 200; i++) begin
      if (xfer_cnt >= base + FRAME_LEN) break;
      @(posedge CLOCK);
      #1;
    end
    check("gap_first_frame", xfer_cnt, base + FRAME_LEN);
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      if (tx_valid) break;
      gap++;
    end
    check("gap_len", gap, GAP + 2);
    @(posedge CLOCK);
    #1;
    wait_idle(400);
    check("gap_sb_empty", sb.size(), 0);
    check("gap_msg_count", msg_count, 10);

    // reset mid-frame at idx 5 with three events queued
    tx_ready = 1'b0;
    base = xfer_cnt;
    send_event(3'd1, 4'd2, 1);
    send_event(3'd2, 4'd3, 1);
    send_event(3'd3, 4'd4, 1);
    send_event(3'd4, 4'd5, 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLOCK);
      #1;
      if (xfer_cnt == base + 5) break;
    end
    tx_ready = 1'b0;
    RESET = 1'b1;
    check("t5_at_idx5", xfer_cnt, base + 5);
    check("t5_pending", sb.size(), 4 * FRAME_LEN - 5);
    sb.delete();
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    check("t5_tx_valid", tx_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_msg_count", msg_count, 0);
    check("t5_overflow", overflow, 0);
    check("t5_event_ready", event_ready, 1);
    @(posedge CLOCK);
    #1;
    tx_ready = 1'b1;
    repeat (60) @(posedge CLOCK);
    #1;
    check("t5_nothing_sent", xfer_cnt, base + 5);
    check("t5_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
